// File: rtl/data_ram_be_lat.sv
// -----------------------------------------------------------------------------
// data_ram_be_lat
//
// Single-port data memory for the jedro_1 data bus. It supports per-byte write
// enables (sb/sh/sw), a request/grant/response handshake and a read latency of
// 1 to 4 cycles. The block never stalls. Every accepted request returns exactly
// one in-order response, READ_LATENCY cycles after its accept edge.
//
// Ports
//   clk_i     in   clock, all logic on the rising edge
//   rst_i     in   synchronous active-high reset (clears the response pipe only)
//   req_i     in   access request
//   we_i      in   1 = write, 0 = read (sampled with req_i)
//   addr_i    in   byte address; word index = addr_i[log2(DEPTH_WORDS)+1:2]
//   be_i      in   byte lanes to access
//   wdata_i   in   lane-aligned write data
//   gnt_o     out  request accepted this cycle (req_i & ~rst_i)
//   rvalid_o  out  one-cycle response pulse per accepted request
//   rdata_o   out  read data (full word; zero for writes and errored reads)
//   err_o     out  access error (illegal be_i or out-of-range address)
// -----------------------------------------------------------------------------
module data_ram_be_lat #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(DEPTH_WORDS);

    // Parameter sanity checks, reported at elaboration.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_ram_be_lat: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("data_ram_be_lat: DATA_WIDTH must be a nonzero multiple of 8");
    end
    if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
        $error("data_ram_be_lat: DEPTH_WORDS must be a power of two");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
        $error("data_ram_be_lat: ADDR_WIDTH too small for DEPTH_WORDS");
    end

    typedef logic [NUM_LANES-1:0] lane_t;

    // One slot of the response pipeline.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    // A legal byte enable is all lanes, or a naturally aligned run of one or
    // two lanes. Zero is never legal.
    function automatic logic be_legal(input lane_t be);
        lane_t one;
        lane_t two;
        logic  ok;
        one    = '0;
        one[0] = 1'b1;
        two    = one | (one << 1);
        ok     = (be == {NUM_LANES{1'b1}});
        for (int k = 0; k < NUM_LANES; k++) begin
            if (be == (one << k)) begin
                ok = 1'b1;
            end
            if ((k % 2 == 0) && (k + 1 < NUM_LANES) && (be == (two << k))) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             acc_err;
    logic             accept;
    logic             unused_addr_bits;

    // The lane choice comes from be_i, so the byte offset is deliberately ignored.
    assign unused_addr_bits = ^addr_i[1:0];
    assign idx              = addr_i[IDX_W+1:2];

    if (ADDR_WIDTH > IDX_W + 2) begin : g_range_check
        assign out_of_range = |addr_i[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range_check
        assign out_of_range = 1'b0;
    end

    assign gnt_o   = req_i & ~rst_i;
    assign accept  = req_i & gnt_o;
    assign acc_err = ~be_legal(be_i) | out_of_range;

    // NOTE: the storage array is not reset. Clearing it would turn a RAM into
    // a huge bank of flops, so reset only touches the response pipeline. The
    // declaration initialiser only sets the power-up contents.
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample their inputs from before the edge, with no ordering races.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !acc_err) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    stage_t stage_in;
    stage_t pipe [READ_LATENCY];

    // NOTE: every field gets a default before any condition. That way no path
    // leaves stage_in unassigned, and no latch is inferred.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.err   = accept & acc_err;
        if (accept && !we_i && !acc_err) begin
            stage_in.data = mem[idx];
        end
    end

    // The RAM is read into stage 1 at the accept edge. A write one cycle
    // earlier has already landed in mem, so read-after-write sees new data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rvalid_o = pipe[READ_LATENCY-1].valid;
    assign err_o    = pipe[READ_LATENCY-1].err;
    assign rdata_o  = pipe[READ_LATENCY-1].data;

endmodule

// File: tb/tb_data_ram_be_lat.sv
// -----------------------------------------------------------------------------
// tb_data_ram_be_lat
//
// Three instances with READ_LATENCY 1, 2 and 3 share one stimulus bus. A
// negedge monitor logs every response per instance, with the cycle it
// appeared in. Each test task drives directed accesses and compares the logged
// responses against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_data_ram_be_lat;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    int   stray_err = 0;
    rsp_t q1 [$];
    rsp_t q2 [$];
    rsp_t q3 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_be_lat #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .ADDR_WIDTH(32), .READ_LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
    data_ram_be_lat #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .ADDR_WIDTH(32), .READ_LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
    data_ram_be_lat #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .ADDR_WIDTH(32), .READ_LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    // Response logger. A response sampled here after posedge k is stamped k.
    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) q1.push_back('{cyc, err[0], rdata[0]});
        if (rvalid[1] === 1'b1) q2.push_back('{cyc, err[1], rdata[1]});
        if (rvalid[2] === 1'b1) q3.push_back('{cyc, err[2], rdata[2]});
        for (int d = 0; d < 3; d++) begin
            if (rvalid[d] !== 1'b1 && err[d] === 1'b1) stray_err++;
        end
    end

    // Drives one request so that it is accepted at the next edge. The accept
    // edge number is returned. The call ends 1 ns after that edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int acc);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        acc   = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        be    = 4'hF;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (gnt !== 3'b000) begin
            bad++; $display("FAIL reset_gnt: got %b want 000", gnt);
        end
        total++;
        if (rvalid !== 3'b000 || err !== 3'b000) begin
            bad++; $display("FAIL reset_rvalid_err: got rvalid=%b err=%b want 000/000", rvalid, err);
        end
        total++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h %h %h want 0", rdata[0], rdata[1], rdata[2]);
        end
        rst = 1'b0;
        #1;
        total++;
        if (gnt !== 3'b111) begin
            bad++; $display("FAIL gnt_req: got %b want 111", gnt);
        end
        req = 1'b0;
        #1;
        total++;
        if (gnt !== 3'b000) begin
            bad++; $display("FAIL gnt_idle: got %b want 000", gnt);
        end
        idle();
        drain(5);
        total++;
        if (q1.size() + q2.size() + q3.size() != 0) begin
            bad++; $display("FAIL reset_no_rsp: got %0d responses want 0", q1.size() + q2.size() + q3.size());
        end
        clear_q();
    endtask

    task automatic test_basic();
        int          acc [4];
        logic [31:0] exp [4] = '{32'h0, 32'h0, 32'hD, 32'hD};
        issue(1'b1, 32'h0, 4'hF, 32'hD, acc[0]);
        issue(1'b1, 32'h4, 4'hF, 32'hD, acc[1]);
        issue(1'b0, 32'h0, 4'hF, 32'h0, acc[2]);
        issue(1'b0, 32'h4, 4'hF, 32'h0, acc[3]);
        idle();
        drain(6);
        total++;
        if (q1.size() != 4 || q3.size() != 4) begin
            bad++; $display("FAIL basic_count: got lat1=%0d lat3=%0d want 4/4", q1.size(), q3.size());
        end
        for (int i = 0; i < 4 && i < q1.size(); i++) begin
            total++;
            if (q1[i].cyc !== acc[i] || q1[i].err !== 1'b0 || q1[i].data !== exp[i]) begin
                bad++; $display("FAIL basic_lat1[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h",
                                i, q1[i].cyc, q1[i].err, q1[i].data, acc[i], exp[i]);
            end
        end
        for (int i = 0; i < 4 && i < q3.size(); i++) begin
            total++;
            if (q3[i].cyc !== acc[i] + 2 || q3[i].err !== 1'b0 || q3[i].data !== exp[i]) begin
                bad++; $display("FAIL basic_lat3[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h",
                                i, q3[i].cyc, q3[i].err, q3[i].data, acc[i] + 2, exp[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_byte_lanes();
        int          acc [4];
        logic [31:0] exp [4] = '{32'h0, 32'h0, 32'h0, 32'h223311DD};
        issue(1'b1, 32'h8, 4'b1111, 32'hAABBCCDD, acc[0]);
        issue(1'b1, 32'h8, 4'b0010, 32'h00001100, acc[1]);
        issue(1'b1, 32'h8, 4'b1100, 32'h22330000, acc[2]);
        issue(1'b0, 32'h8, 4'b1111, 32'h0,        acc[3]);
        idle();
        drain(6);
        total++;
        if (q2.size() != 4) begin
            bad++; $display("FAIL lanes_count: got %0d want 4", q2.size());
        end
        for (int i = 0; i < 4 && i < q2.size(); i++) begin
            total++;
            if (q2[i].cyc !== acc[i] + 1 || q2[i].err !== 1'b0 || q2[i].data !== exp[i]) begin
                bad++; $display("FAIL lanes_lat2[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h",
                                i, q2[i].cyc, q2[i].err, q2[i].data, acc[i] + 1, exp[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_errors();
        int          acc [7];
        logic        xerr [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp  [7] = '{32'h0, 32'hD, 32'h0, 32'hD, 32'h0, 32'h0, 32'hD};
        issue(1'b1, 32'h00001000, 4'b1111, 32'hFFFFFFFF, acc[0]); // out of range write
        issue(1'b0, 32'h00000000, 4'b1111, 32'h0,        acc[1]); // word 0 untouched
        issue(1'b1, 32'h00000000, 4'b0110, 32'hFFFFFFFF, acc[2]); // misaligned half
        issue(1'b0, 32'h00000000, 4'b1111, 32'h0,        acc[3]); // word 0 untouched
        issue(1'b0, 32'h00000000, 4'b0000, 32'h0,        acc[4]); // empty be
        issue(1'b0, 32'h80000004, 4'b1111, 32'h0,        acc[5]); // out of range read
        issue(1'b0, 32'h00000003, 4'b1111, 32'h0,        acc[6]); // offset bits ignored
        idle();
        drain(6);
        total++;
        if (q1.size() != 7) begin
            bad++; $display("FAIL err_count: got %0d want 7", q1.size());
        end
        for (int i = 0; i < 7 && i < q1.size(); i++) begin
            total++;
            if (q1[i].cyc !== acc[i] || q1[i].err !== xerr[i] || q1[i].data !== exp[i]) begin
                bad++; $display("FAIL err_lat1[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=%b data=%h",
                                i, q1[i].cyc, q1[i].err, q1[i].data, acc[i], xerr[i], exp[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int acc [4];
        int dummy;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'(4 * i), 4'hF, 32'(i + 1), dummy);
        end
        idle();
        drain(6);
        clear_q();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'(4 * i), 4'hF, 32'h0, acc[i]);
        end
        idle();
        drain(6);
        total++;
        if (q3.size() != 4) begin
            bad++; $display("FAIL b2b_count: got %0d want 4", q3.size());
        end
        for (int i = 0; i < 4 && i < q3.size(); i++) begin
            total++;
            if (q3[i].cyc !== acc[0] + 2 + i || q3[i].err !== 1'b0 || q3[i].data !== 32'(i + 1)) begin
                bad++; $display("FAIL b2b_lat3[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h",
                                i, q3[i].cyc, q3[i].err, q3[i].data, acc[0] + 2 + i, i + 1);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int          acc [5];
        logic [31:0] exp [3] = '{32'h3, 32'h4, 32'h1};
        issue(1'b0, 32'h0, 4'hF, 32'h0, acc[0]);
        issue(1'b0, 32'h4, 4'hF, 32'h0, acc[1]);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First requests straight after reset release.
        issue(1'b0, 32'h8, 4'hF, 32'h0, acc[2]);
        issue(1'b0, 32'hC, 4'hF, 32'h0, acc[3]);
        issue(1'b0, 32'h0, 4'hF, 32'h0, acc[4]);
        idle();
        drain(6);
        total++;
        if (q1.size() != 5 || q2.size() != 4 || q3.size() != 3) begin
            bad++; $display("FAIL rstmid_count: got lat1=%0d lat2=%0d lat3=%0d want 5/4/3",
                            q1.size(), q2.size(), q3.size());
        end
        for (int i = 0; i < 3 && i < q3.size(); i++) begin
            total++;
            if (q3[i].cyc !== acc[i + 2] + 2 || q3[i].err !== 1'b0 || q3[i].data !== exp[i]) begin
                bad++; $display("FAIL rstmid_lat3[%0d]: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h",
                                i, q3[i].cyc, q3[i].err, q3[i].data, acc[i + 2] + 2, exp[i]);
            end
        end
        if (q2.size() > 0) begin
            total++;
            if (q2[0].cyc !== acc[0] + 1 || q2[0].data !== 32'h1) begin
                bad++; $display("FAIL rstmid_lat2_first: got cyc=%0d data=%h want cyc=%0d data=1",
                                q2[0].cyc, q2[0].data, acc[0] + 1);
            end
        end
        clear_q();
    endtask

    task automatic test_raw();
        int acc_w;
        int acc_r;
        issue(1'b1, 32'hC, 4'hF, 32'h5, acc_w);
        issue(1'b0, 32'hC, 4'hF, 32'h0, acc_r);
        idle();
        drain(6);
        total++;
        if (q2.size() != 2) begin
            bad++; $display("FAIL raw_count: got %0d want 2", q2.size());
        end else begin
            total++;
            if (q2[0].cyc !== acc_w + 1 || q2[0].err !== 1'b0 || q2[0].data !== 32'h0) begin
                bad++; $display("FAIL raw_write_rsp: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=0",
                                q2[0].cyc, q2[0].err, q2[0].data, acc_w + 1);
            end
            total++;
            if (q2[1].cyc !== acc_r + 1 || q2[1].err !== 1'b0 || q2[1].data !== 32'h5) begin
                bad++; $display("FAIL raw_read_rsp: got cyc=%0d err=%b data=%h want cyc=%0d err=0 data=5",
                                q2[1].cyc, q2[1].err, q2[1].data, acc_r + 1);
            end
        end
        if (q1.size() == 2) begin
            total++;
            if (q1[1].data !== 32'h5) begin
                bad++; $display("FAIL raw_lat1: got data=%h want 5", q1[1].data);
            end
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_raw();
        total++;
        if (stray_err !== 0) begin
            bad++; $display("FAIL err_without_rvalid: got %0d cycles want 0", stray_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_be_lat.md
Name: data_ram_be_lat

Overview:
Parametrised single-port data memory for the jedro_1 data bus. It adds per-byte write enables for sb/sh/sw, a request/grant/response handshake, and a configurable read latency of 1 to 4 cycles. It also flags out-of-range and illegal byte-enable accesses. It replaces the fixed 32-bit, word-only, single-latency data RAM wrapper behind the core's data interface.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
DEPTH_WORDS, 1024, number of words; power of two.
ADDR_WIDTH, 32, byte-address width on addr_i.
READ_LATENCY, 1, cycles from accept to response; legal range 1..4, elaborated as error otherwise.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req_i  in  1  access request
we_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  ADDR_WIDTH  byte address; word index = addr_i[log2(DEPTH_WORDS)+1:2]
be_i  in  DATA_WIDTH/8  byte lanes to access
wdata_i  in  DATA_WIDTH  write data, lane-aligned (byte k in bits 8k+7:8k)
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid, one-cycle pulse per accepted request
rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o
err_o  out  1  access error, valid with rvalid_o

Behaviour:
- Reset (rst_i=1 at a clock edge): rvalid_o=0, err_o=0, rdata_o=0, whole response pipeline cleared. In-flight responses are dropped. Memory contents are not cleared. gnt_o=0 while rst_i=1.
- Grant: gnt_o = req_i & ~rst_i (combinational). The block never stalls and accepts one request every cycle.
- Accept: an access is accepted in any cycle with req_i & gnt_o at the rising edge.
- Legal be_i for 32-bit words: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - For other widths, a legal be_i is a naturally aligned contiguous run of 1, 2 or all lanes.
  - be_i=0 is illegal.
- Error: an accepted access is in error if be_i is illegal, or if addr_i's upper bits beyond the word index are nonzero (out of range). addr_i[1:0] is ignored; be_i selects the lanes.
- Write, no error: only the enabled bytes of RAM[index] update at the accept edge. Other bytes are unchanged.
- Write with error: no memory change.
- Read: rdata_o returns the full word. Disabled lanes are not masked; the core does the extract and sign-extend. An errored read returns rdata_o=0.
- Response timing: every accepted request gives exactly one rvalid_o pulse, exactly READ_LATENCY cycles after the accept edge. Responses come back in order.
  - For writes, rdata_o=0.
  - err_o is asserted only with rvalid_o, otherwise 0.
- Pipeline: a READ_LATENCY-deep shift register of {valid, err, data}. The RAM read happens at stage 1, so back-to-back accepts produce back-to-back responses.
- Read-after-write: a read accepted the cycle after a write to the same word returns the updated word.
- Memory initial contents are all zero at time 0 (simulation init).
- Reset asserted mid-burst: pulses scheduled after the reset edge never appear. The first request after rst_i falls is served normally.

Test Plan:
1. READ_LATENCY=1: write 0x0000000D to addr 0 and addr 4 with be=1111, then read both -> rvalid pulses 1 cycle after each read accept; rdata 0x0000000D twice; err_o=0.
2. Byte/half writes: sw 0xAABBCCDD @8; sb 0x11 be=0010 (wdata 0x00001100); sh 0x2233 be=1100 (wdata 0x22330000) -> read @8 returns 0x223311DD.
3. Errors (DEPTH_WORDS=1024): write @0x00001000 be=1111 -> err_o=1 with rvalid; RAM unchanged. be=0110 @0 -> err_o=1, word 0 unchanged. be=0000 -> err_o=1.
4. READ_LATENCY=3: four back-to-back reads of words 0..3 preloaded 1,2,3,4 -> rvalid high on 4 consecutive cycles starting 3 cycles after the first accept; data 1,2,3,4 in order.
5. READ_LATENCY=3: two reads accepted, rst_i=1 for one cycle on the next edge -> no rvalid pulses. Memory keeps its contents; a read after reset returns the stored values.
6. Write 0x5 @12 then read @12 on the next cycle (READ_LATENCY=2) -> rdata_o=0x5 with rvalid 2 cycles after the read accept.
